// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: PC, IR, register file, A/B/ALUOut/MDR staging
// registers and ALU, sequenced cycle by cycle by an external control_unit.
module multicycle_datapath #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  PC_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [5:0]        opCode,
    input  logic [5:0]        ALUOp,
    input  logic [1:0]        PCWriteCond,
    input  logic [1:0]        ALUSrcB,
    input  logic [1:0]        PCSource,
    input  logic              PCWrite,
    input  logic              IorD,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              IRWrite,
    input  logic              ALUSrcA,
    input  logic              RegWrite,
    input  logic              RegDst,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pc_out
);

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rf [32];

    logic [DATA_W-1:0] ext_imm;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [5:0]        eff_func;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] pc_next;
    logic              pc_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign opCode    = ir[31:26];
    assign pc_out    = pc;
    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_we    = MemWrite;

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        if (opCode == OP_ANDI || opCode == OP_ORI || opCode == OP_XORI)
            ext_imm = {16'h0000, ir[15:0]};
        else
            ext_imm = {{16{ir[15]}}, ir[15:0]};
    end

    always_comb begin
        src_a = ALUSrcA ? a_reg : pc;
        case (ALUSrcB)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = 32'd4;
            2'b10:   src_b = {ext_imm[29:0], 2'b00};
            default: src_b = ext_imm;
        endcase
    end

    // The IR funct field only drives the ALU in the R-type execute step
    // (A vs B); a zero ALUOp otherwise means ADD, not SLL.
    always_comb begin
        if (opCode == OP_RTYPE && ALUSrcA && ALUSrcB == 2'b00)
            eff_func = ir[5:0];
        else if (ALUOp == 6'b000000)
            eff_func = FN_ADD;
        else
            eff_func = ALUOp;
    end

    always_comb begin
        alu_result = src_a + src_b;
        case (eff_func)
            FN_SUB:  alu_result = src_a - src_b;
            FN_AND:  alu_result = src_a & src_b;
            FN_OR:   alu_result = src_a | src_b;
            FN_XOR:  alu_result = src_a ^ src_b;
            FN_NOR:  alu_result = ~(src_a | src_b);
            FN_SLL:  alu_result = src_b << ir[10:6];
            FN_SRL:  alu_result = src_b >> ir[10:6];
            FN_MULT: alu_result = src_a * src_b;
            FN_DIV:  alu_result = (src_b == '0) ? '1 : (src_a / src_b);
            default: alu_result = src_a + src_b;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        case (PCSource)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = alu_out;
            2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
            default: pc_next = pc;
        endcase
        pc_en = PCWrite
              | ((PCWriteCond == 2'b01) &  zero)
              | ((PCWriteCond == 2'b10) & ~zero);
    end

    always_comb begin
        if (RegDst)
            wr_addr = 5'd31;
        else if (opCode == OP_RTYPE)
            wr_addr = ir[15:11];
        else
            wr_addr = ir[20:16];
        wr_data = MemtoReg ? mdr : alu_result;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= PC_RESET;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if (pc_en && PCSource != 2'b11)
                pc <= pc_next;
            if (IRWrite)
                ir <= mem_rdata;
            a_reg   <= rf[ir[25:21]];
            b_reg   <= rf[ir[20:16]];
            alu_out <= alu_result;
            mdr     <= mem_rdata;
        end
    end

    // $0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (RegWrite && wr_addr != 5'd0) begin
            rf[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: table of ALU/immediate instructions
// plus hand-written branch, jump, memory, wrap and reset sequences.
module tb_multicycle_datapath;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opCode;
    logic [5:0]  ALUOp;
    logic [1:0]  PCWriteCond, ALUSrcB, PCSource;
    logic        PCWrite, IorD, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic        mem_we;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  bsel;
        logic [5:0]  aluop;
        int          rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    multicycle_datapath dut (
        .clk(clk), .reset(reset), .opCode(opCode), .ALUOp(ALUOp),
        .PCWriteCond(PCWriteCond), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        ALUOp = 6'd0; PCWriteCond = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00;
        PCWrite = 0; IorD = 0; MemWrite = 0; MemtoReg = 0; IRWrite = 0;
        ALUSrcA = 0; RegWrite = 0; RegDst = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] instr);
        clear_ctrl();
        IRWrite = 1; mem_rdata = instr;
        step();
        clear_ctrl();
    endtask

    // Reads a register through B: load a lw with rt=k into IR, then B shows RF[k].
    task automatic read_reg(input int k, output logic [31:0] v);
        logic [4:0] r;
        r = k[4:0];
        fetch({6'h23, 5'd0, r, 16'h0000});
        step();
        v = mem_wdata;
    endtask

    task automatic run_alu(input logic [31:0] instr, input logic [1:0] bsel, input logic [5:0] aluop);
        fetch(instr);
        step();                                         // DECODE
        ALUSrcA = 1; ALUSrcB = bsel; ALUOp = aluop; RegWrite = 1;
        step();                                         // EXECUTE
        clear_ctrl();
        step();                                         // INCREMENT_PC
        PCWrite = 1; ALUSrcB = 2'b01; PCSource = 2'b00;
        step();                                         // INCREMENT_PC_EXECUTE
        clear_ctrl();
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] exp_pc;

        vecs[0]  = '{32'h2001FFFF, 2'b11, FN_ADD, 1,  32'hFFFFFFFF}; // addi $1,$0,-1
        vecs[1]  = '{32'h3402FFFF, 2'b11, FN_OR,  2,  32'h0000FFFF}; // ori $2,$0,0xffff
        vecs[2]  = '{32'h20010007, 2'b11, FN_ADD, 1,  32'h00000007}; // addi $1,$0,7
        vecs[3]  = '{32'h20020003, 2'b11, FN_ADD, 2,  32'h00000003}; // addi $2,$0,3
        vecs[4]  = '{32'h00221822, 2'b00, 6'd0,   3,  32'h00000004}; // sub $3,$1,$2
        vecs[5]  = '{32'h20020000, 2'b11, FN_ADD, 2,  32'h00000000}; // addi $2,$0,0
        vecs[6]  = '{32'h0022181A, 2'b00, 6'd0,   3,  32'hFFFFFFFF}; // div $3,$1,$2 (by 0)
        vecs[7]  = '{32'h20040001, 2'b11, FN_ADD, 4,  32'h00000001}; // addi $4,$0,1
        vecs[8]  = '{32'h00042900, 2'b00, 6'd0,   5,  32'h00000010}; // sll $5,$4,4
        vecs[9]  = '{32'h20000005, 2'b11, FN_ADD, 0,  32'h00000000}; // addi $0,$0,5
        vecs[10] = '{32'h2006FFFD, 2'b11, FN_ADD, 6,  32'hFFFFFFFD}; // addi $6,$0,-3
        vecs[11] = '{32'h00C13818, 2'b00, 6'd0,   7,  32'hFFFFFFEB}; // mult $7,$6,$1
        vecs[12] = '{32'h38288000, 2'b11, FN_XOR, 8,  32'h00008007}; // xori $8,$1,0x8000
        vecs[13] = '{32'h20298000, 2'b11, FN_ADD, 9,  32'hFFFF8007}; // addi $9,$1,-32768
        vecs[14] = '{32'h000850C2, 2'b00, 6'd0,   10, 32'h00001000}; // srl $10,$8,3
        vecs[15] = '{32'h00225827, 2'b00, 6'd0,   11, 32'hFFFFFFF8}; // nor $11,$1,$2
        vecs[16] = '{32'h00046700, 2'b00, 6'd0,   12, 32'h10000000}; // sll $12,$4,28

        // Reset with every strobe asserted
        reset = 0; mem_rdata = 32'hFFFFFFFF;
        ALUOp = 6'h3F; PCWriteCond = 2'b11; ALUSrcB = 2'b11; PCSource = 2'b11;
        PCWrite = 1; IorD = 1; MemWrite = 1; MemtoReg = 1; IRWrite = 1;
        ALUSrcA = 1; RegWrite = 1; RegDst = 1;
        step(); step();
        check("reset_pc", pc_out, 32'h0);
        check("reset_opcode", {26'd0, opCode}, 32'h0);
        check("reset_mem_we", {31'd0, mem_we}, 32'h1);
        reset = 1; clear_ctrl(); mem_rdata = 32'h0;
        step(); step(); step();
        check("idle_pc_hold", pc_out, 32'h0);
        check("idle_mem_addr", mem_addr, 32'h0);
        for (int k = 1; k < 32; k++) begin
            read_reg(k, rv);
            check($sformatf("reset_rf%0d", k), rv, 32'h0);
        end

        // Table of single-register ALU instructions, each a full 5-step sequence
        exp_pc = 32'h0;
        for (int i = 0; i < 17; i++) begin
            run_alu(vecs[i].instr, vecs[i].bsel, vecs[i].aluop);
            exp_pc = exp_pc + 32'd4;
            check($sformatf("vec%0d_opcode", i), {26'd0, opCode}, {26'd0, vecs[i].instr[31:26]});
            check($sformatf("vec%0d_pc", i), pc_out, exp_pc);
            read_reg(vecs[i].rd, rv);
            check($sformatf("vec%0d_rf%0d", i, vecs[i].rd), rv, vecs[i].exp);
        end

        // beq $2,$0,-1 from PC 0x44: target 0x40, operands equal -> taken
        fetch(32'h1040FFFF);
        ALUSrcB = 2'b10; ALUOp = FN_ADD;
        step();
        clear_ctrl(); ALUSrcA = 1; ALUOp = FN_SUB; PCWriteCond = 2'b01; PCSource = 2'b01;
        step(); clear_ctrl();
        check("beq_taken_pc", pc_out, 32'h00000040);

        // beq $1,$2 with 7 vs 0 -> not taken
        fetch(32'h1022FFFF);
        ALUSrcB = 2'b10; ALUOp = FN_ADD;
        step();
        clear_ctrl(); ALUSrcA = 1; ALUOp = FN_SUB; PCWriteCond = 2'b01; PCSource = 2'b01;
        step(); clear_ctrl();
        check("beq_not_taken_pc", pc_out, 32'h00000040);

        // PCWrite overrides a failing bne condition (zero=1, PCWriteCond=10)
        fetch(32'h1040FFFF);
        ALUSrcB = 2'b10; ALUOp = FN_ADD;
        step();
        clear_ctrl(); ALUSrcA = 1; ALUOp = FN_SUB; PCWriteCond = 2'b10; PCSource = 2'b01; PCWrite = 1;
        step(); clear_ctrl();
        check("pcwrite_override_pc", pc_out, 32'h0000003C);

        PCWrite = 1; PCSource = 2'b11;
        step(); clear_ctrl();
        check("pcsource11_hold", pc_out, 32'h0000003C);

        // PC <- $12 + 0 = 0x1000_0000, then j 0x10 with a $31 link write
        fetch(32'h21800000);
        step();
        ALUSrcA = 1; ALUSrcB = 2'b11; ALUOp = FN_ADD; PCWrite = 1; PCSource = 2'b00;
        step(); clear_ctrl();
        check("set_pc", pc_out, 32'h10000000);
        fetch(32'h08000010);
        step();
        PCWrite = 1; PCSource = 2'b10; RegWrite = 1; RegDst = 1; ALUSrcB = 2'b01; ALUOp = FN_ADD;
        step(); clear_ctrl();
        check("jump_pc", pc_out, 32'h10000040);
        read_reg(31, rv);
        check("link_rf31", rv, 32'h10000004);

        // sw $1,8($12): address phase then store strobe
        fetch(32'hAD810008);
        step();
        ALUSrcA = 1; ALUSrcB = 2'b11; ALUOp = FN_ADD;
        step(); clear_ctrl();
        IorD = 1; MemWrite = 1;
        #1;
        check("store_mem_addr", mem_addr, 32'h10000008);
        check("store_mem_we", {31'd0, mem_we}, 32'h1);
        check("store_mem_wdata", mem_wdata, 32'h00000007);
        step(); clear_ctrl();
        #1;
        check("after_store_mem_we", {31'd0, mem_we}, 32'h0);
        check("after_store_mem_addr", mem_addr, 32'h10000040);

        // lw $13,16($12): write-back must come from MDR, not live mem_rdata
        fetch(32'h8D8D0010);
        step();
        ALUSrcA = 1; ALUSrcB = 2'b11; ALUOp = FN_ADD;
        step(); clear_ctrl();
        IorD = 1; mem_rdata = 32'hCAFEBABE;
        #1;
        check("load_mem_addr", mem_addr, 32'h10000010);
        step(); clear_ctrl();
        mem_rdata = 32'h0; RegWrite = 1; MemtoReg = 1;
        step(); clear_ctrl();
        read_reg(13, rv);
        check("load_rf13", rv, 32'hCAFEBABE);

        // PC <- $11 + 4 = 0xFFFF_FFFC, then +4 wraps to 0
        fetch(32'h21600004);
        step();
        ALUSrcA = 1; ALUSrcB = 2'b11; ALUOp = FN_ADD; PCWrite = 1; PCSource = 2'b00;
        step(); clear_ctrl();
        check("pc_near_top", pc_out, 32'hFFFFFFFC);
        PCWrite = 1; ALUSrcB = 2'b01;
        step();
        check("pc_wrap", pc_out, 32'h00000000);
        step(); clear_ctrl();
        check("pc_after_wrap", pc_out, 32'h00000004);

        // Reset mid-instruction with writes pending
        reset = 0; mem_rdata = 32'hFFFFFFFF;
        PCWrite = 1; ALUSrcB = 2'b01; RegWrite = 1; RegDst = 1; IRWrite = 1;
        step();
        reset = 1; clear_ctrl(); mem_rdata = 32'h0;
        check("midreset_pc", pc_out, 32'h0);
        check("midreset_opcode", {26'd0, opCode}, 32'h0);
        read_reg(31, rv);
        check("midreset_rf31", rv, 32'h0);
        read_reg(13, rv);
        check("midreset_rf13", rv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Multicycle MIPS-subset datapath driven cycle by cycle by `control_unit`. It holds the PC, IR, register file, A/B/ALUOut/MDR staging registers and the ALU. It returns the opcode to the controller and drives a single shared instruction/data memory port, applying every control strobe at the next rising clock edge.

## Interface
- `DATA_W`, 32: datapath width (fixed 32; parameter for documentation only)
- `PC_RESET`, 32'h0000_0000: PC value after reset
- `clk`  in  1: sole clock, all state updates on rising edge
- `reset`  in  1: synchronous, active-low; sampled on `clk` rising edge
- `opCode`  out  6: IR[31:26] to `control_unit`
- `ALUOp`  in  6: ALU function code (funct encoding); 6'b000000 = ADD unless R-type rule applies
- `PCWriteCond`  in  2: 00 none, 01 write PC if zero, 10 write PC if not zero, 11 none
- `ALUSrcB`  in  2: 00 B, 01 constant 4, 10 ext(imm)<<2, 11 ext(imm)
- `PCSource`  in  2: 00 ALU result, 01 ALUOut, 10 {PC[31:28], IR[25:0], 2'b00}, 11 hold PC
- `PCWrite`, `IorD`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  in  1 each: control strobes
- `mem_addr`  out  32: IorD ? ALUOut : PC
- `mem_wdata`  out  32: B register
- `mem_we`  out  1: equals MemWrite
- `mem_rdata`  in  32: combinational read data for `mem_addr`
- `pc_out`  out  32: current PC (debug)

## Operation
- ALU operand A: ALUSrcA ? A : PC. Operand B per ALUSrcB.
- ext(imm): zero-extend IR[15:0] when opcode is ANDI (001100), ORI (001101) or XORI (001110); otherwise sign-extend.
- Effective function:
  - IR funct IR[5:0] when opcode==0 && ALUSrcA==1 && ALUSrcB==00.
  - Otherwise ALUOp, with 6'b000000 treated as ADD.
- Functions:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SLL 000000 and SRL 000010: operand B shifted by IR[10:6].
  - MULT 011000: low 32 bits of the unsigned product.
  - DIV 011010: unsigned quotient; divisor 0 → 32'hFFFF_FFFF.
  - Unlisted codes → ADD.
- zero = (ALU result == 0).
- PC load, evaluated in priority order:
  - If PCWrite, PC ← PCSource mux.
  - Else if PCWriteCond is 01 and zero, or 10 and !zero, PC ← PCSource mux.
  - PCSource 11 leaves PC unchanged even when enabled.
- IR ← mem_rdata when IRWrite, else hold.
- Staging registers load unconditionally every cycle:
  - A ← RF[IR[25:21]]
  - B ← RF[IR[20:16]]
  - ALUOut ← ALU result
  - MDR ← mem_rdata
- Register file:
  - 32×32, asynchronous read, write on edge when RegWrite.
  - Destination: RegDst=1 → $31. RegDst=0 → IR[15:11] if opcode==0, else IR[20:16].
  - Write data: MemtoReg ? MDR : current-cycle ALU result.
  - Writes to $0 are discarded; $0 always reads 0.
- Read of a register written in the same cycle returns the old value.

## Timing
- Reset (reset==0 at edge) overrides all writes: PC=PC_RESET, IR=A=B=ALUOut=MDR=0, all 32 registers 0, so opCode=0 and pc_out=PC_RESET. mem_we follows MemWrite combinationally, also during reset.
- Controller sequence FETCH→DECODE→EXECUTE→INCREMENT_PC→INCREMENT_PC_EXECUTE:
  - IR valid and opCode updated the cycle after FETCH.
  - A/B valid the cycle after DECODE.
  - RegWrite in EXECUTE commits at the end of EXECUTE.
  - PC+4 commits at the end of INCREMENT_PC_EXECUTE (ALUSrcA=0, ALUSrcB=01, PCSource=00).
  - Jumps (PCWrite in EXECUTE, PCSource=10) commit at the end of EXECUTE.
- mem_addr, mem_we and mem_wdata are combinational from current state and strobes. A store writes in the cycle MemWrite is high.
- Reset mid-instruction: the state listed above on the next edge, with no partial register-file or PC write.
- PC wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Test plan
- Reset: hold reset=0 two cycles with all strobes driven 1 → PC=0, opCode=0, RF[1..31]=0; release, and all strobes 0 for 3 cycles → PC holds 0.
- ADDI: mem_rdata=0x2001_FFFF (addi $1,$0,-1); drive the controller's ADDI sequence (FETCH, DECODE, EXECUTE with ALUSrcA=1, ALUSrcB=11, ALUOp=ADD, RegWrite=1, then INCREMENT_PC, INCREMENT_PC_EXECUTE with PCWrite=1, PCSource=00) → RF[1]=0xFFFF_FFFF, PC=4; ORI with imm 0xFFFF → zero-extended 0x0000_FFFF.
- R-type: RF[1]=7, RF[2]=3, IR=sub $3,$1,$2 → RF[3]=4. Same with funct DIV and RF[2]=0 → RF[3]=0xFFFF_FFFF. SLL shamt 4 on 1 → 0x10.
- $0 protection: addi $0,$0,5 → RF[0] reads 0 afterwards.
- Branch: PCWriteCond=01, PCSource=01, ALUOut=0x40, operands equal → PC=0x40; operands unequal → PC unchanged; PCWrite=1 with PCWriteCond=10 and zero=1 → PC written.
- Jump/memory: PC=0x1000_0000, IR=J 0x0000010 → PC=0x1000_0040. IorD=1 with MemWrite=1 → mem_addr=ALUOut, mem_we=1, mem_wdata=B.
